// File: rtl/display_pkg.sv
// Shared definitions for the display owner arbiter and the board display decoder.
// Contents:
//   N_REQ       - number of requesters (fixed at 8, 3-bit owner index)
//   arb_state_t - arbiter FSM states
//   DIGIT       - 7-segment patterns (gfedcba) for digits 0..7
package display_pkg;

   localparam int N_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } arb_state_t;

   localparam logic [6:0] DIGIT [8] = '{
      7'b0111111,
      7'b0000110,
      7'b1011011,
      7'b1001111,
      7'b1100110,
      7'b1101101,
      7'b1111101,
      7'b0000111
   };

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational priority picker for the owner arbiter.
// Ports:
//   eligible [7:0] in  - requesters that may be granted this cycle
//   start    [2:0] in  - first index examined in round-robin mode
//   rr_en          in  - 1 = descending search from start with wrap, 0 = highest index wins
//   valid          out - at least one eligible requester
//   idx      [2:0] out - winning index (0 when valid=0)
module rr_prio_pick
   import display_pkg::*;
(
   input  logic [7:0] eligible,
   input  logic [2:0] start,
   input  logic       rr_en,
   output logic       valid,
   output logic [2:0] idx
);

   logic [2:0] base;
   logic [2:0] cand;

   // Walk downward from the base index; the 3-bit subtraction gives the
   // wrap from 0 back to 7. Fixed priority is just a search starting at 7.
   always_comb begin
      base  = rr_en ? start : 3'd7;
      valid = 1'b0;
      idx   = 3'd0;
      cand  = base;
      for (int i = 0; i < N_REQ; i++) begin
         cand = base - 3'(i);
         if (!valid && eligible[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/display_owner_arbiter.sv
// Arbitrates one shared resource among 8 level-sensitive requesters and shows
// the current owner index on the board 7-segment display.
// Parameters:
//   MAX_HOLD - cycles a grant may be held before it is revoked (0 = never)
//   RR_EN    - 0 = fixed priority (7 highest), 1 = round-robin after each release
// Ports:
//   clk            in  - rising-edge clock
//   rst            in  - synchronous reset, active-high
//   req      [7:0] in  - request per requester, held while the resource is wanted
//   grant    [7:0] out - one-hot grant, zero when idle
//   owner    [2:0] out - index of current owner, keeps last value while idle
//   busy           out - a grant is active
//   timeout        out - one-cycle pulse when a grant is revoked by MAX_HOLD
//   segments [6:0] out - gfedcba digit of owner, zero when idle
//   none           out - decimal point, lit when no grant is active
module display_owner_arbiter
   import display_pkg::*;
#(
   parameter int MAX_HOLD = 255,
   parameter bit RR_EN    = 1'b0
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] owner,
   output logic       busy,
   output logic       timeout,
   output logic [6:0] segments,
   output logic       none
);

   localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

   arb_state_t state;
   arb_state_t state_next;

   logic [7:0] hold_cnt;
   logic [7:0] pen_mask;
   logic [7:0] eligible;
   logic [2:0] rr_last;
   logic [2:0] rr_start;
   logic [2:0] pick_idx;
   logic       pick_valid;
   logic       do_grant;
   logic       do_release;
   logic       do_timeout;

   // A requester that timed out stays masked until it drops req once.
   assign eligible = req & ~pen_mask;
   assign rr_start = rr_last - 3'd1;

   rr_prio_pick u_pick (
      .eligible (eligible),
      .start    (rr_start),
      .rr_en    (RR_EN),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. RELEASE is the single dead cycle between owners: the
   // outputs are already cleared, so a waiting requester is picked during it
   // and granted on the following edge; with nobody waiting we settle in IDLE.
   // A dropped request takes precedence over an expiring hold count, so a
   // simultaneous release never raises timeout or penalises the owner.
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_release = 1'b0;
      do_timeout = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               do_grant   = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               do_release = 1'b1;
               state_next = RELEASE;
            end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
               do_release = 1'b1;
               do_timeout = 1'b1;
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (pick_valid) begin
               do_grant   = 1'b1;
               state_next = GRANT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and output registers. The display is loaded on the same edge
   // as grant so the digit never lags the owner. rr_last is captured as the
   // grant ends so the pick in the dead cycle already rotates past it.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant    <= 8'd0;
         owner    <= 3'd0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         segments <= 7'd0;
         none     <= 1'b1;
         hold_cnt <= 8'd0;
         pen_mask <= 8'd0;
         rr_last  <= 3'd0;
      end else begin
         pen_mask <= (pen_mask & req) | (do_timeout ? (8'd1 << owner) : 8'd0);
         timeout  <= do_timeout;
         if (do_grant) begin
            grant    <= 8'd1 << pick_idx;
            owner    <= pick_idx;
            busy     <= 1'b1;
            segments <= DIGIT[pick_idx];
            none     <= 1'b0;
            hold_cnt <= 8'd0;
         end else begin
            if (hold_cnt != 8'hFF) begin
               hold_cnt <= hold_cnt + 8'd1;
            end
            if (do_release) begin
               grant    <= 8'd0;
               busy     <= 1'b0;
               segments <= 7'd0;
               none     <= 1'b1;
               rr_last  <= owner;
            end
         end
      end
   end

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Self-checking bench for display_owner_arbiter.
// Two instances run side by side: a fixed-priority arbiter with a 4-cycle hold
// limit and a round-robin arbiter with a 6-cycle hold limit. A driver applies
// directed phases followed by random traffic, steps a behavioural model of
// each arbiter and queues the expected outputs; a monitor pops and compares.
module tb_display_owner_arbiter;

   typedef struct packed {
      logic [7:0] grant;
      logic [2:0] owner;
      logic       busy;
      logic       timeout;
      logic [6:0] segments;
      logic       none;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_a;
   logic [7:0] req_b;
   obs_t       out_a;
   obs_t       out_b;

   int num_checks = 0;
   int num_fails  = 0;

   obs_t exp_q [2][$];

   // Model configuration and state, one slot per instance.
   int         cfg_rr  [2] = '{0, 1};
   int         cfg_max [2] = '{4, 6};
   bit         m_owned [2];
   int         m_owner [2];
   int         m_age   [2];
   int         m_last  [2];
   bit         m_to    [2];
   logic [7:0] m_pen   [2];

   logic [6:0] seg_table [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

   always #5 clk = ~clk;

   display_owner_arbiter #(.MAX_HOLD(4), .RR_EN(1'b0)) dut_fix (
      .clk      (clk),
      .rst      (rst),
      .req      (req_a),
      .grant    (out_a.grant),
      .owner    (out_a.owner),
      .busy     (out_a.busy),
      .timeout  (out_a.timeout),
      .segments (out_a.segments),
      .none     (out_a.none)
   );

   display_owner_arbiter #(.MAX_HOLD(6), .RR_EN(1'b1)) dut_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (req_b),
      .grant    (out_b.grant),
      .owner    (out_b.owner),
      .busy     (out_b.busy),
      .timeout  (out_b.timeout),
      .segments (out_b.segments),
      .none     (out_b.none)
   );

   // Winner among eligible requesters: highest index, or in round-robin mode
   // the first one found walking down from just below the previous owner.
   function automatic int pick_winner(input int n, input logic [7:0] e);
      int k;
      for (int d = 1; d <= 8; d++) begin
         k = (cfg_rr[n] != 0) ? ((m_last[n] - d + 8) % 8) : (8 - d);
         if (e[k]) return k;
      end
      return -1;
   endfunction

   // Advance the model of instance n by one clock edge and return the outputs
   // visible after that edge.
   function automatic obs_t model_step(input int n, input logic r, input logic [7:0] q);
      logic [7:0] elig;
      int         k;
      obs_t       o;
      if (r) begin
         m_owned[n] = 1'b0;
         m_owner[n] = 0;
         m_age[n]   = 0;
         m_last[n]  = 0;
         m_to[n]    = 1'b0;
         m_pen[n]   = 8'd0;
      end else begin
         elig     = q & ~m_pen[n];
         m_pen[n] = m_pen[n] & q;
         m_to[n]  = 1'b0;
         if (m_owned[n]) begin
            if (!q[m_owner[n]]) begin
               m_owned[n] = 1'b0;
               m_last[n]  = m_owner[n];
            end else if (cfg_max[n] != 0 && m_age[n] == cfg_max[n]) begin
               m_owned[n] = 1'b0;
               m_last[n]  = m_owner[n];
               m_to[n]    = 1'b1;
               m_pen[n][m_owner[n]] = 1'b1;
            end else begin
               m_age[n]++;
            end
         end else begin
            k = pick_winner(n, elig);
            if (k >= 0) begin
               m_owned[n] = 1'b1;
               m_owner[n] = k;
               m_age[n]   = 1;
            end
         end
      end
      o.grant    = m_owned[n] ? (8'd1 << m_owner[n]) : 8'd0;
      o.owner    = 3'(m_owner[n]);
      o.busy     = m_owned[n];
      o.timeout  = m_to[n];
      o.segments = m_owned[n] ? seg_table[m_owner[n]] : 7'd0;
      o.none     = !m_owned[n];
      return o;
   endfunction

   // A requester that gives the resource back after holding it two cycles.
   function automatic logic [7:0] react_req(input int n, input logic [7:0] q);
      if (m_owned[n] && m_age[n] >= 2) return q & ~(8'd1 << m_owner[n]);
      return q;
   endfunction

   task automatic applyStimulus(input logic r, input logic [7:0] qa, input logic [7:0] qb);
      @(negedge clk);
      rst   = r;
      req_a = qa;
      req_b = qb;
      exp_q[0].push_back(model_step(0, r, qa));
      exp_q[1].push_back(model_step(1, r, qb));
   endtask

   task automatic run_phase(input logic r, input logic [7:0] q, input int cycles, input bit react);
      for (int c = 0; c < cycles; c++) begin
         if (react) applyStimulus(r, react_req(0, q), react_req(1, q));
         else       applyStimulus(r, q, q);
      end
   endtask

   task automatic checkOutput(input int n, input obs_t act, input obs_t exp_v);
      num_checks++;
      if (act !== exp_v) begin
         num_fails++;
         $display("[TB] FAIL dut%0d outputs t=%0t: got grant=%h owner=%0d busy=%b to=%b seg=%b none=%b, expected grant=%h owner=%0d busy=%b to=%b seg=%b none=%b",
                  n, $time, act.grant, act.owner, act.busy, act.timeout, act.segments, act.none,
                  exp_v.grant, exp_v.owner, exp_v.busy, exp_v.timeout, exp_v.segments, exp_v.none);
      end
   endtask

   // Monitor: compare each registered output set just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q[0].size() > 0) checkOutput(0, out_a, exp_q[0].pop_front());
         if (exp_q[1].size() > 0) checkOutput(1, out_b, exp_q[1].pop_front());
      end
   end

   // Driver: directed phases, then random traffic with occasional resets.
   initial begin
      logic [7:0] cur;
      int         left;
      rst   = 1'b1;
      req_a = 8'h00;
      req_b = 8'h00;

      run_phase(1'b1, 8'h00, 2, 1'b0);
      run_phase(1'b0, 8'h00, 10, 1'b0);
      run_phase(1'b0, 8'h24, 3, 1'b0);
      run_phase(1'b0, 8'h04, 4, 1'b0);
      run_phase(1'b0, 8'h00, 2, 1'b0);
      run_phase(1'b0, 8'h80, 9, 1'b0);
      run_phase(1'b0, 8'h00, 1, 1'b0);
      run_phase(1'b0, 8'h80, 4, 1'b0);
      run_phase(1'b0, 8'h00, 2, 1'b0);
      run_phase(1'b0, 8'h80, 4, 1'b0);
      run_phase(1'b0, 8'h00, 3, 1'b0);
      run_phase(1'b0, 8'h81, 16, 1'b1);
      run_phase(1'b0, 8'h00, 2, 1'b0);
      run_phase(1'b0, 8'h08, 3, 1'b0);
      run_phase(1'b1, 8'hFF, 1, 1'b0);
      run_phase(1'b0, 8'hFF, 3, 1'b0);
      run_phase(1'b0, 8'h00, 2, 1'b0);

      cur = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
         end
         if ($urandom_range(0, 3) == 0) run_phase(1'b0, cur, 1, 1'b1);
         else run_phase(($urandom_range(0, 199) == 0), cur, 1, 1'b0);
      end

      repeat (3) @(negedge clk);
      left = exp_q[0].size() + exp_q[1].size();
      num_checks++;
      if (left != 0) begin
         num_fails++;
         $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", left);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
